// File: rtl/spi_slave_port.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave_port
//
// SPI mode-0 responder clocked entirely by i_Clk. SCLK, CS_n and MOSI from an
// external master are oversampled through synchronisers. Received words are
// assembled MSB first into o_RX_Byte with a one-cycle o_RX_DV strobe. A
// single-entry holding register feeds the transmit shifter that drives MISO
// during the same transfer.
//
// Ports
//   i_Clk          system clock
//   i_Rst          asynchronous active-high reset
//   i_SPI_Clk      master SCLK (asynchronous)
//   i_SPI_CS_n     master chip select, active low (asynchronous)
//   i_SPI_MOSI     master data out (asynchronous)
//   o_SPI_MISO     responder data out, 0 while deselected
//   o_RX_Byte      last complete received word
//   o_RX_DV        one-cycle strobe: o_RX_Byte updated
//   i_TX_Byte      next word to transmit
//   i_TX_DV        load strobe for i_TX_Byte, honoured only while o_TX_Ready
//   o_TX_Ready     transmit holding register is empty
//   o_TX_Underrun  sticky: a word started with no transmit data loaded
// -----------------------------------------------------------------------------
module spi_slave_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_SPI_Clk,
  input  logic             i_SPI_CS_n,
  input  logic             i_SPI_MOSI,
  output logic             o_SPI_MISO,
  output logic [WIDTH-1:0] o_RX_Byte,
  output logic             o_RX_DV,
  input  logic [WIDTH-1:0] i_TX_Byte,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic             o_TX_Underrun
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [WIDTH-1:0] rx_shift, rx_next;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic [CNT_W-1:0] bit_cnt;
  logic             active;
  logic             tx_load;
  logic             tx_accept;

  // ---------------------------------------------------------------------------
  // Synchronisers and registered edge strobes. The CS_n chain resets low so a
  // master that is still selected when reset releases produces no cs_fall:
  // the first word after reset needs a genuine fresh CS_n falling edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its neighbour, which is what turns this into a shift chain.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   i_SPI_CS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_rise <=  sclk_sync[SYNC_STAGES-1] & ~sclk_d;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] &  sclk_d;
      cs_fall   <= ~cs_sync[SYNC_STAGES-1]   &  cs_d;
      cs_rise   <=  cs_sync[SYNC_STAGES-1]   & ~cs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Select FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: assigning every output first means no path leaves a value
    // unassigned, so no latch can be inferred.
    state_d   = state_q;
    active    = (state_q == ACTIVE);
    rx_next   = {rx_shift[WIDTH-2:0], mosi_sync[SYNC_STAGES-1]};
    // A transmit word is pulled at select and at every word boundary.
    tx_load   = cs_fall |
                (active & ~cs_rise & sclk_fall & (bit_cnt == '0));
    tx_accept = i_TX_DV & ~hold_full;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive path and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rx_shift  <= '0;
      bit_cnt   <= '0;
      o_RX_Byte <= '0;
      o_RX_DV   <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (cs_rise || cs_fall) begin
        // Deselect discards any partial word; select starts a clean one.
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (active && sclk_rise) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          o_RX_Byte <= rx_next;
          o_RX_DV   <= 1'b1;
          bit_cnt   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit shifter, holding register and underrun flag. A load and an
  // accept in the same cycle are independent: the shifter takes the old
  // holding contents, and the accept is gated by the pre-edge ready state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      tx_shift      <= '0;
      hold_data     <= '0;
      hold_full     <= 1'b0;
      o_TX_Underrun <= 1'b0;
    end else begin
      if (cs_rise) begin
        tx_shift <= '0;
      end else if (tx_load) begin
        tx_shift <= hold_full ? hold_data : '0;
      end else if (active && sclk_fall) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end

      if (tx_load) begin
        if (cs_fall)         o_TX_Underrun <= ~hold_full;
        else if (!hold_full) o_TX_Underrun <= 1'b1;
      end

      if (tx_accept) begin
        hold_data <= i_TX_Byte;
        hold_full <= 1'b1;
      end else if (tx_load && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign o_TX_Ready = ~hold_full;
  assign o_SPI_MISO = active & tx_shift[WIDTH-1];

endmodule

// File: tb/tb_spi_slave_port.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_slave_port
//
// Directed bench for spi_slave_port (WIDTH=8, SYNC_STAGES=2). A behavioural
// mode-0 master drives SCLK with 8 i_Clk periods per phase and captures MISO
// on each rising edge. Expected values are written out by hand per scenario.
// -----------------------------------------------------------------------------
module tb_spi_slave_port;

  localparam int HALF = 8;   // i_Clk periods per SCLK phase (1 MHz at 16 MHz)

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;
  logic       tx_underrun;

  int n_cmp  = 0;
  int n_err  = 0;
  int dv_cnt = 0;
  int dv_base;
  logic [7:0] got;

  spi_slave_port #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_SPI_Clk     (sclk),
    .i_SPI_CS_n    (cs_n),
    .i_SPI_MOSI    (mosi),
    .o_SPI_MISO    (miso),
    .o_RX_Byte     (rx_byte),
    .o_RX_DV       (rx_dv),
    .i_TX_Byte     (tx_byte),
    .i_TX_DV       (tx_dv),
    .o_TX_Ready    (tx_ready),
    .o_TX_Underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  // Counts high cycles of o_RX_DV; a stretched strobe counts more than once.
  always @(negedge clk) begin
    if (rx_dv === 1'b1) dv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Mode-0 transfer of nbits MSB first; MISO sampled at each SCLK rise.
  task automatic spi_word(input logic [7:0] data, input int nbits,
                          output logic [7:0] captured);
    captured = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[7-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      captured = {captured[6:0], miso};
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic tx_pulse(input logic [7:0] data);
    tx_byte = data;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_dv   = 1'b0;
  endtask

  // Waits (bounded) for o_TX_Ready, then loads one word.
  task automatic tx_load(input logic [7:0] data);
    int waited;
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_pulse(data);
  endtask

  initial begin
    rst     = 1'b1;
    sclk    = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    tx_byte = '0;
    tx_dv   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_miso",     {31'd0, miso},        32'd0);
    check("rst_rx_byte",  {24'd0, rx_byte},     32'h00);
    check("rst_rx_dv",    {31'd0, rx_dv},       32'd0);
    check("rst_ready",    {31'd0, tx_ready},    32'd1);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);

    // Single word: TX 0xA5, RX 0x3C
    tx_load(8'hA5);
    check("single_ready_low", {31'd0, tx_ready}, 32'd0);
    dv_base = dv_cnt;
    cs_low();
    check("single_ready_after_load", {31'd0, tx_ready}, 32'd1);
    check("single_no_underrun", {31'd0, tx_underrun}, 32'd0);
    spi_word(8'h3C, 8, got);
    cs_high();
    check("single_rx_byte", {24'd0, rx_byte}, 32'h3C);
    check("single_dv_pulses", dv_cnt - dv_base, 32'd1);
    check("single_miso", {24'd0, got}, 32'hA5);
    check("idle_miso", {31'd0, miso}, 32'd0);

    // Burst of three words under one select
    tx_load(8'h11);
    dv_base = dv_cnt;
    cs_low();
    check("burst_underrun_cleared", {31'd0, tx_underrun}, 32'd0);
    tx_load(8'h22);
    spi_word(8'h01, 8, got);
    check("burst0_rx", {24'd0, rx_byte}, 32'h01);
    check("burst0_miso", {24'd0, got}, 32'h11);
    tx_load(8'h33);
    spi_word(8'h80, 8, got);
    check("burst1_rx", {24'd0, rx_byte}, 32'h80);
    check("burst1_miso", {24'd0, got}, 32'h22);
    spi_word(8'hFF, 8, got);
    check("burst2_rx", {24'd0, rx_byte}, 32'hFF);
    check("burst2_miso", {24'd0, got}, 32'h33);
    cs_high();
    check("burst_dv_pulses", dv_cnt - dv_base, 32'd3);

    // Underrun: nothing loaded
    cs_low();
    check("underrun_set_at_select", {31'd0, tx_underrun}, 32'd1);
    spi_word(8'h69, 8, got);
    cs_high();
    check("underrun_miso", {24'd0, got}, 32'h00);
    check("underrun_sticky", {31'd0, tx_underrun}, 32'd1);
    check("underrun_rx", {24'd0, rx_byte}, 32'h69);
    tx_load(8'h42);
    cs_low();
    check("underrun_cleared", {31'd0, tx_underrun}, 32'd0);
    spi_word(8'h96, 8, got);
    cs_high();
    check("after_underrun_miso", {24'd0, got}, 32'h42);
    check("after_underrun_rx", {24'd0, rx_byte}, 32'h96);

    // Abort after 5 bits of 0xF0
    dv_base = dv_cnt;
    cs_low();
    spi_word(8'hF0, 5, got);
    cs_high();
    check("abort_no_dv", dv_cnt - dv_base, 32'd0);
    check("abort_rx_kept", {24'd0, rx_byte}, 32'h96);
    check("abort_miso_idle", {31'd0, miso}, 32'd0);
    cs_low();
    spi_word(8'h5A, 8, got);
    cs_high();
    check("abort_next_rx", {24'd0, rx_byte}, 32'h5A);
    check("abort_next_dv", dv_cnt - dv_base, 32'd1);

    // TX handshake: second strobe while not ready is dropped
    tx_load(8'h77);
    tx_pulse(8'h99);
    check("hs_ready_low", {31'd0, tx_ready}, 32'd0);
    cs_low();
    spi_word(8'h00, 8, got);
    cs_high();
    check("hs_miso", {24'd0, got}, 32'h77);
    check("hs_99_dropped", {31'd0, tx_underrun}, 32'd1);
    check("hs_ready_after", {31'd0, tx_ready}, 32'd1);

    // Reset mid-word, then a clean transfer
    tx_load(8'hE7);
    cs_low();
    spi_word(8'hAA, 4, got);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_miso",     {31'd0, miso},        32'd0);
    check("midrst_rx_byte",  {24'd0, rx_byte},     32'h00);
    check("midrst_rx_dv",    {31'd0, rx_dv},       32'd0);
    check("midrst_ready",    {31'd0, tx_ready},    32'd1);
    check("midrst_underrun", {31'd0, tx_underrun}, 32'd0);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    check("postrst_miso_idle", {31'd0, miso}, 32'd0);
    dv_base = dv_cnt;
    cs_high();
    cs_low();
    spi_word(8'hC3, 8, got);
    cs_high();
    check("postrst_rx", {24'd0, rx_byte}, 32'hC3);
    check("postrst_dv", dv_cnt - dv_base, 32'd1);
    check("postrst_miso", {24'd0, got}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
